rv32_mdu: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the RV32M operations next to the single-cycle ALU in the execute stage. Operands are captured on a start pulse, and the unit computes in radix-2 (one bit per cycle). It returns the result with a one-cycle done pulse, and the core stalls on `Busy` while the unit runs.

---
 rtl/rv32_mdu.sv | 165 ++++++++++++++++
 tb/tb_rv32_mdu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit (MUL*/DIV*/REM*), one result bit per cycle.
// Optional early-out path for trivial operands is enabled by defining RV32_MDU_EARLY_OUT_EN.
module rv32_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start,
  input  logic [2:0]      MDUOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MDURes
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
`ifdef RV32_MDU_EARLY_OUT_EN
  localparam logic [1:0] EARLY = 2'd3;
`endif

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   mb;
  logic [XLEN-1:0]   res_q;
  logic              neg_a;
  logic              neg_b;
  logic              fin;
  logic [2*XLEN-1:0] prod;

  // Operand conditioning at request time
  logic            a_signed_in, b_signed_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0] ma_in, mb_in;

  always_comb begin
    a_signed_in = (MDUOp inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    b_signed_in = (MDUOp inside {3'b000, 3'b001, 3'b100, 3'b110});
    neg_a_in    = a_signed_in & A[XLEN-1];
    neg_b_in    = b_signed_in & B[XLEN-1];
    ma_in       = neg_a_in ? -A : A;
    mb_in       = neg_b_in ? -B : B;
  end

`ifdef RV32_MDU_EARLY_OUT_EN
  logic early_in;
  always_comb begin
    if (MDUOp[2])
      early_in = (B == '0) || (!MDUOp[0] && (A == MIN_NEG) && (B == '1));
    else
      early_in = (A == '0) || (B == '0);
  end
`endif

  // One iteration step; prod holds {acc, multiplier} or {remainder, quotient}
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mb} : '0);
    mul_step  = {mul_sum, prod[XLEN-1:1]};
    div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, mb};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  prod[XLEN-2:0], 1'b1};
  end

  // Sign correction and RISC-V special-case resolution
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;
  logic              b_zero, ovf;

  always_comb begin
    prod_s  = (neg_a ^ neg_b) ? -prod : prod;
    quo_s   = (neg_a ^ neg_b) ? -prod[XLEN-1:0] : prod[XLEN-1:0];
    rem_s   = neg_a ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    b_zero  = (mb == '0);
    ovf     = !op[0] && neg_b && (mb == XLEN'(1)) && (a_q == MIN_NEG);
    fix_res = '0;
    if (!op[2]) begin
      fix_res = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      if ((a_q == '0) || b_zero)
        fix_res = '0;
    end else if (b_zero) begin
      fix_res = op[1] ? a_q : '1;
    end else if (ovf) begin
      fix_res = op[1] ? '0 : a_q;
    end else begin
      fix_res = op[1] ? rem_s : quo_s;
    end
  end

  // FIX stages the corrected result in res_q; fin publishes it one edge later,
  // keeping Busy high until the Done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      a_q    <= '0;
      mb     <= '0;
      res_q  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      fin    <= 1'b0;
      prod   <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      MDURes <= '0;
    end else begin
      Done <= 1'b0;
      fin  <= 1'b0;
      case (state)
        IDLE: begin
          if (fin) begin
            MDURes <= res_q;
            Done   <= 1'b1;
            Busy   <= 1'b0;
          end else if (Start) begin
            op    <= MDUOp;
            a_q   <= A;
            mb    <= mb_in;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            prod  <= {{XLEN{1'b0}}, ma_in};
            cnt   <= CW'(XLEN);
            Busy  <= 1'b1;
`ifdef RV32_MDU_EARLY_OUT_EN
            state <= early_in ? EARLY : CALC;
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          prod <= op[2] ? div_step : mul_step;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          res_q <= fix_res;
          fin   <= 1'b1;
          state <= IDLE;
        end
`ifdef RV32_MDU_EARLY_OUT_EN
        EARLY: begin
          MDURes <= fix_res;
          Done   <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mdu.sv
// Self-checking bench for rv32_mdu: directed RV32M cases, protocol/reset scenarios,
// an XLEN=16 instance, and randomized operations against an arithmetic reference model.
module tb_rv32_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] MDURes;

  logic        h_start;
  logic [2:0]  h_op;
  logic [15:0] h_a, h_b;
  logic        h_busy, h_done;
  logic [15:0] h_res;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef RV32_MDU_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  rv32_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .MDURes(MDURes)
  );

  rv32_mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .Start(h_start), .MDUOp(h_op), .A(h_a), .B(h_b),
    .Busy(h_busy), .Done(h_done), .MDURes(h_res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint    sa, sb, ua, ub;
    logic [63:0] p;
    int        ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit trivial;
    if (op[2])
      trivial = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else
      trivial = (a == 32'd0) || (b == 32'd0);
    return (EARLY_EN && trivial) ? 1 : 34;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge just after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    MDUOp = 3'($urandom);
  endtask

  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!Done && lat < 200) begin
      if (Busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    res = MDURes;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        dirs[$];
    logic [31:0] res;
    int          lat, busy_n, cnt, extra;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst = 1'b1; Start = 1'b0; MDUOp = '0; A = '0; B = '0;
    h_start = 1'b0; h_op = '0; h_a = '0; h_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_res", MDURes, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    dirs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    dirs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    dirs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    dirs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
    dirs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    dirs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    dirs.push_back('{3'd5, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF});
    dirs.push_back('{3'd7, 32'd17,         32'd5,         32'd2});
    dirs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF});
    dirs.push_back('{3'd7, 32'd5,          32'd0,         32'd5});
    dirs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dirs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
    dirs.push_back('{3'd0, 32'd0,          32'h1234_5678, 32'd0});

    foreach (dirs[i]) begin
      issue(dirs[i].op, dirs[i].a, dirs[i].b);
      wait_done(res, lat, busy_n);
      check($sformatf("dir%0d_res", i), res, dirs[i].exp);
      check($sformatf("dir%0d_lat", i), 32'(lat), 32'(exp_lat(dirs[i].op, dirs[i].a, dirs[i].b)));
      check($sformatf("dir%0d_busy", i), 32'(busy_n), 32'(exp_lat(dirs[i].op, dirs[i].a, dirs[i].b)));
      @(negedge clk);
      check($sformatf("dir%0d_pulse", i), 32'(Done), 32'd0);
      check($sformatf("dir%0d_hold", i), MDURes, dirs[i].exp);
    end

    // A second request while busy must be dropped
    issue(3'd0, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    MDUOp = 3'd5; A = 32'd9; B = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(res, lat, busy_n);
    check("busy_start_res", res, 32'd42);
    check("busy_start_lat", 32'(lat + 6), 32'd34);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      extra += int'(Done);
    end
    check("busy_start_extra_done", 32'(extra), 32'd0);

    // New request in the Done cycle
    issue(3'd7, 32'd100, 32'd9);
    wait_done(res, lat, busy_n);
    check("b2b_first_res", res, 32'd1);
    issue(3'd3, 32'd3, 32'd5);
    wait_done(res, lat, busy_n);
    check("b2b_second_res", res, 32'd0);
    check("b2b_second_lat", 32'(lat), 32'd34);
    @(negedge clk);

    // Reset mid-operation
    issue(3'd5, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_res", MDURes, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(Done);
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    issue(3'd5, 32'd100, 32'd7);
    wait_done(res, lat, busy_n);
    check("postrst_res", res, 32'd14);
    check("postrst_lat", 32'(lat), 32'd34);

    // XLEN=16 instance
    h_op = 3'd3; h_a = 16'hFFFF; h_b = 16'hFFFF; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0; h_a = '0; h_b = '0;
    lat = 0;
    while (!h_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("x16_res", 32'(h_res), 32'h0000_FFFE);
    check("x16_lat", 32'(lat), 32'd18);

    // Randomized, issued back-to-back in each Done cycle
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      issue(op, a, b);
      wait_done(res, lat, busy_n);
      check($sformatf("rand%0d_op%0d_res", i, op), res, ref_mdu(op, a, b));
      check($sformatf("rand%0d_op%0d_lat", i, op), 32'(lat), 32'(exp_lat(op, a, b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
